// File: rtl/pmc_matrix_responder_if.sv
// PMC strobe/shift bus between the matrix controller (master) and the pixel-matrix responder (slave).
// Carries the control lines plus the per-column serial lines in both directions.
interface pmc_matrix_responder_if #(
  parameter int COLS = 16
);
  logic            clk_sh;
  logic            sh_a;
  logic            sh_b;
  logic            gate;
  logic            strobe;
  logic            store;
  logic [COLS-1:0] dout;
  logic [COLS-1:0] din;
  logic            sel_err;

  modport master (
    output clk_sh, sh_a, sh_b, gate, strobe, store, dout,
    input  din, sel_err
  );

  modport slave (
    input  clk_sh, sh_a, sh_b, gate, strobe, store, dout,
    output din, sel_err
  );
endinterface

// File: rtl/pmc_matrix_responder.sv
// Pixel-matrix emulator answering the PMC shift/strobe protocol: per-pixel config and hit counters,
// readout registers latched on store, and per-column serial chains returned on din.
module pmc_matrix_responder #(
  parameter int COLS  = 16,
  parameter int ROWS  = 8,
  parameter int CNT_W = 8,
  parameter int CFG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pmc_matrix_responder_if.slave bus
);
  localparam int R_LEN = ROWS * CNT_W;
  localparam int K_LEN = ROWS * CFG_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            clk_sh_q;
  logic            strobe_q;
  logic            store_q;
  logic            sh_edge;
  logic            stb_edge;
  logic            st_edge;
  logic            sel_r;
  logic            sel_k;
  logic            sel_bad;
  logic            r_shift;
  logic            k_shift;
  logic            hit;
  logic [COLS-1:0] din_q;
  logic [COLS-1:0] din_d;
  logic            sel_err_q;
  logic            sel_err_d;

  // History resets to 0, so a line already high at reset release is seen as a rising edge.
  assign sh_edge  = bus.clk_sh & ~clk_sh_q;
  assign stb_edge = bus.strobe & ~strobe_q;
  assign st_edge  = bus.store  & ~store_q;

  assign sel_r   = bus.sh_a & ~bus.sh_b;
  assign sel_k   = bus.sh_b & ~bus.sh_a;
  assign sel_bad = bus.sh_a &  bus.sh_b;

  // A store in the same cycle owns the readout chain, so the R shift is dropped.
  assign r_shift   = sh_edge & sel_r & ~st_edge;
  assign k_shift   = sh_edge & sel_k;
  assign hit       = stb_edge & bus.gate;
  assign sel_err_d = sh_edge & sel_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sh_q  <= 1'b0;
      strobe_q  <= 1'b0;
      store_q   <= 1'b0;
      din_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      clk_sh_q  <= bus.clk_sh;
      strobe_q  <= bus.strobe;
      store_q   <= bus.store;
      din_q     <= din_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.din     = din_q;
  assign bus.sel_err = sel_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [R_LEN-1:0] r_q;
      logic [R_LEN-1:0] r_d;
      logic [R_LEN-1:0] cnt_flat;
      logic [K_LEN-1:0] k_q;
      logic [K_LEN-1:0] k_d;
      logic [CNT_W-1:0] cnt_q [ROWS];
      logic [CNT_W-1:0] cnt_d [ROWS];

      // Counters clear on store even when a hit arrives in the same cycle; that hit is lost.
      always_comb begin
        cnt_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
          cnt_flat[r*CNT_W +: CNT_W] = cnt_q[r];
          cnt_d[r] = cnt_q[r];
          if (st_edge) begin
            cnt_d[r] = '0;
          end else if (hit && k_q[r*CFG_W] && (cnt_q[r] != CNT_MAX)) begin
            cnt_d[r] = cnt_q[r] + CNT_W'(1);
          end
        end
      end

      always_comb begin
        r_d = r_q;
        k_d = k_q;
        if (st_edge) begin
          r_d = cnt_flat;
        end else if (r_shift) begin
          r_d = {r_q[R_LEN-2:0], bus.dout[gi]};
        end
        if (k_shift) begin
          k_d = {k_q[K_LEN-2:0], bus.dout[gi]};
        end
      end

      // din presents the bit that leaves on the next shift; it freezes while a store reloads R.
      assign din_d[gi] = sel_r ? (st_edge ? din_q[gi] : r_d[R_LEN-1]) :
                         sel_k ? k_d[K_LEN-1] : 1'b0;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q <= '0;
          k_q <= '0;
          for (int r = 0; r < ROWS; r++) begin
            cnt_q[r] <= '0;
          end
        end else begin
          r_q <= r_d;
          k_q <= k_d;
          for (int r = 0; r < ROWS; r++) begin
            cnt_q[r] <= cnt_d[r];
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_pmc_matrix_responder.sv
// Directed bench for pmc_matrix_responder: table of count/store scenarios plus hand sequences
// for reset release, config load, event collisions and the select-error pulse.
module tb_pmc_matrix_responder;
  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int LEN  = 64;
  localparam int NVEC = 5;

  typedef struct {
    int         strobes;
    bit         gate;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  int             checks = 0;
  int             errors = 0;
  logic [LEN-1:0] rb [COLS];
  vec_t           vecs [NVEC];
  logic [COLS-1:0] din_before;

  pmc_matrix_responder_if #(.COLS(COLS)) bus ();

  pmc_matrix_responder #(
    .COLS(COLS), .ROWS(ROWS), .CNT_W(8), .CFG_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic bit pix_en(int c, int r);
    return (c != 0) || (r % 2 == 0);
  endfunction

  function automatic logic [LEN-1:0] cfg_word(int c);
    logic [LEN-1:0] w;
    logic [3:0]     cc;
    logic [2:0]     rr;
    w  = '0;
    cc = c[3:0];
    for (int r = 0; r < ROWS; r++) begin
      rr = r[2:0];
      w[r*8 +: 8] = {cc, rr, pix_en(c, r)};
    end
    return w;
  endfunction

  function automatic logic [LEN-1:0] cnt_word(int c, logic [7:0] v);
    logic [LEN-1:0] w;
    w = '0;
    for (int r = 0; r < ROWS; r++) begin
      w[r*8 +: 8] = pix_en(c, r) ? v : 8'h00;
    end
    return w;
  endfunction

  task automatic set_sel(input logic a, input logic b);
    bus.sh_a = a;
    bus.sh_b = b;
    tick();
  endtask

  task automatic shift_one(input logic [COLS-1:0] d, output logic [COLS-1:0] cap);
    cap        = bus.din;
    bus.dout   = d;
    bus.clk_sh = 1'b1;
    tick();
    bus.clk_sh = 1'b0;
    bus.dout   = '0;
    tick();
  endtask

  // Reads the selected chain of every column, feeding each bit back in so contents survive.
  task automatic readback();
    logic [COLS-1:0] cap;
    for (int i = 0; i < LEN; i++) begin
      shift_one(bus.din, cap);
      for (int c = 0; c < COLS; c++) rb[c][LEN-1-i] = cap[c];
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] v, input bit is_cfg);
    for (int c = 0; c < COLS; c++) begin
      check($sformatf("%s col%0d", tag, c), rb[c], is_cfg ? cfg_word(c) : cnt_word(c, v));
    end
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.strobe = 1'b1;
      tick();
      bus.strobe = 1'b0;
      tick();
    end
  endtask

  task automatic store_pulse();
    bus.store = 1'b1;
    tick();
    bus.store = 1'b0;
    tick();
  endtask

  task automatic read_r(input string tag, input logic [7:0] v);
    set_sel(1'b1, 1'b0);
    readback();
    check_all(tag, v, 1'b0);
    set_sel(1'b0, 1'b0);
  endtask

  initial begin
    logic [COLS-1:0] d;
    logic [COLS-1:0] cap;
    logic [LEN-1:0]  cw;

    vecs[0] = '{5,   1'b1, 8'h05, "count5"};
    vecs[1] = '{0,   1'b1, 8'h00, "restore0"};
    vecs[2] = '{300, 1'b1, 8'hFF, "saturate"};
    vecs[3] = '{10,  1'b0, 8'h00, "gated"};
    vecs[4] = '{1,   1'b1, 8'h01, "single"};

    // Reset with every input high; release produces edges on all three lines at once.
    bus.clk_sh = 1'b1; bus.sh_a = 1'b1; bus.sh_b = 1'b1; bus.gate = 1'b1;
    bus.strobe = 1'b1; bus.store = 1'b1; bus.dout = '1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset din", 64'(bus.din), 64'd0);
    check("reset sel_err", 64'(bus.sel_err), 64'd0);
    rst_n = 1'b1;
    tick();
    check("release sel_err pulse", 64'(bus.sel_err), 64'd1);
    check("release din", 64'(bus.din), 64'd0);
    bus.clk_sh = 1'b0; bus.sh_a = 1'b0; bus.sh_b = 1'b0; bus.gate = 1'b0;
    bus.strobe = 1'b0; bus.store = 1'b0; bus.dout = '0;
    tick();
    check("release sel_err clear", 64'(bus.sel_err), 64'd0);

    // Config load, MSB of pixel 7 first, then non-destructive readback.
    set_sel(1'b0, 1'b1);
    for (int i = 0; i < LEN; i++) begin
      for (int c = 0; c < COLS; c++) begin
        cw   = cfg_word(c);
        d[c] = cw[LEN-1-i];
      end
      shift_one(d, cap);
    end
    readback();
    check_all("cfg load", 8'h00, 1'b1);
    set_sel(1'b0, 1'b0);

    for (int v = 0; v < NVEC; v++) begin
      bus.gate = vecs[v].gate;
      strobes(vecs[v].strobes);
      store_pulse();
      read_r(vecs[v].name, vecs[v].exp);
    end

    // store + strobe in one cycle: readout keeps the pre-hit count, the hit is lost.
    bus.gate = 1'b1;
    strobes(3);
    bus.strobe = 1'b1;
    bus.store  = 1'b1;
    tick();
    bus.strobe = 1'b0;
    bus.store  = 1'b0;
    tick();
    read_r("store+strobe", 8'h03);
    strobes(2);
    store_pulse();
    read_r("after collide", 8'h02);

    // store + R shift in one cycle: din holds and R is loaded, not shifted.
    set_sel(1'b1, 1'b0);
    strobes(4);
    din_before = bus.din;
    bus.dout   = '1;
    bus.clk_sh = 1'b1;
    bus.store  = 1'b1;
    tick();
    check("store+shift din hold", 64'(bus.din), 64'(din_before));
    bus.clk_sh = 1'b0;
    bus.store  = 1'b0;
    bus.dout   = '0;
    tick();
    readback();
    check_all("store+shift R", 8'h04, 1'b0);
    set_sel(1'b0, 1'b0);

    // Illegal select: one-cycle sel_err, din forced low, no chain touched.
    set_sel(1'b1, 1'b1);
    check("sel11 din", 64'(bus.din), 64'd0);
    check("sel11 idle sel_err", 64'(bus.sel_err), 64'd0);
    bus.dout   = '1;
    bus.clk_sh = 1'b1;
    tick();
    check("sel_err pulse", 64'(bus.sel_err), 64'd1);
    check("sel_err din", 64'(bus.din), 64'd0);
    bus.clk_sh = 1'b0;
    bus.dout   = '0;
    tick();
    check("sel_err one cycle", 64'(bus.sel_err), 64'd0);
    set_sel(1'b0, 1'b1);
    readback();
    check_all("sel_err K kept", 8'h00, 1'b1);
    set_sel(1'b1, 1'b0);
    readback();
    check_all("sel_err R kept", 8'h04, 1'b0);
    set_sel(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
